plane_ctrl: RTL and testbench

PLANE_CTRL -- requirements
Module: plane_ctrl

---
 rtl/plane_pkg.sv | 24 ++
 rtl/plane_axis.sv | 69 ++++++
 rtl/plane_ctrl.sv | 139 +++++++++++++
 tb/tb_plane_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/plane_pkg.sv
// Shared constants and types for the plane controller.
//   SCREEN_W/SCREEN_H : visible VGA area in pixels
//   PLANE_W/PLANE_H   : plane sprite size in pixels
//   COORD_W           : width of every screen coordinate
//   FIRE_X_OFS        : horizontal offset from plane left edge to gun muzzle
//   DROP_W            : width of the dropped-shot counter
//   fire_state_e      : states of the fire request FSM
package plane_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PLANE_W    = 32;
    localparam int PLANE_H    = 32;
    localparam int COORD_W    = 10;
    localparam int FIRE_X_OFS = PLANE_W / 2;
    localparam int DROP_W     = 8;

    typedef enum logic [1:0] {
        FIRE_IDLE = 2'd0,
        FIRE_REQ  = 2'd1,
        FIRE_COOL = 2'd2
    } fire_state_e;

endpackage

// File: rtl/plane_axis.sv
// One movement axis of the plane.
// Direction pulses latch into pending flags; on tick the flags are applied
// as a single saturating step and cleared. A pulse in the tick cycle itself
// counts towards that tick.
//   clk, rst : clock, synchronous active-high reset
//   dec_evt  : pulse requesting a move towards 0 (left / up)
//   inc_evt  : pulse requesting a move towards MAX (right / down)
//   tick     : frame tick, applies and clears the pending flags
//   pos      : current coordinate, updated the cycle after tick
module plane_axis
    import plane_pkg::*;
#(
    parameter int STEP  = 8,
    parameter int MAX   = 608,
    parameter int START = 304
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_evt,
    input  logic               inc_evt,
    input  logic               tick,
    output logic [COORD_W-1:0] pos
);

    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] MAX_C   = COORD_W'(MAX);
    localparam logic [COORD_W-1:0] START_C = COORD_W'(START);

    logic               dec_pend_q, dec_pend_d;
    logic               inc_pend_q, inc_pend_d;
    logic [COORD_W-1:0] pos_q, pos_d;
    logic               dec_now, inc_now;
    logic [COORD_W:0]   pos_inc;

    always_comb begin
        dec_now    = dec_pend_q | dec_evt;
        inc_now    = inc_pend_q | inc_evt;
        // One extra bit so pos+STEP cannot wrap before the limit compare.
        pos_inc    = {1'b0, pos_q} + {1'b0, STEP_C};
        dec_pend_d = dec_now;
        inc_pend_d = inc_now;
        pos_d      = pos_q;
        if (tick) begin
            dec_pend_d = 1'b0;
            inc_pend_d = 1'b0;
            // Opposing requests cancel: neither branch fires.
            if (dec_now && !inc_now) begin
                pos_d = (pos_q < STEP_C) ? '0 : pos_q - STEP_C;
            end else if (inc_now && !dec_now) begin
                pos_d = (pos_inc > {1'b0, MAX_C}) ? MAX_C : pos_inc[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q      <= START_C;
            dec_pend_q <= 1'b0;
            inc_pend_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            dec_pend_q <= dec_pend_d;
            inc_pend_q <= inc_pend_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/plane_ctrl.sv
// Player plane controller: per-frame movement and a bullet launch handshake.
//   clk, rst                    : clock, synchronous active-high reset
//   up/down/left/right          : debounced single-cycle direction pulses
//   shoot                       : debounced single-cycle fire pulse
//   frame_tick                  : single-cycle pulse at each frame start
//   plane_x, plane_y            : plane top-left corner
//   fire_valid/fire_ready       : launch request handshake to bullet engine
//   fire_x, fire_y              : bullet start point, held during the request
//   drop_cnt                    : saturating count of discarded shoot pulses
module plane_ctrl
    import plane_pkg::*;
#(
    parameter int STEP     = 8,
    parameter int X_MAX    = SCREEN_W - PLANE_W,
    parameter int Y_MAX    = SCREEN_H - PLANE_H,
    parameter int X_START  = 304,
    parameter int Y_START  = 440,
    parameter int COOLDOWN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               shoot,
    input  logic               frame_tick,
    output logic [COORD_W-1:0] plane_x,
    output logic [COORD_W-1:0] plane_y,
    output logic               fire_valid,
    output logic [COORD_W-1:0] fire_x,
    output logic [COORD_W-1:0] fire_y,
    input  logic               fire_ready,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    plane_axis #(
        .STEP  (STEP),
        .MAX   (X_MAX),
        .START (X_START)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .dec_evt (left),
        .inc_evt (right),
        .tick    (frame_tick),
        .pos     (plane_x)
    );

    plane_axis #(
        .STEP  (STEP),
        .MAX   (Y_MAX),
        .START (Y_START)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .dec_evt (up),
        .inc_evt (down),
        .tick    (frame_tick),
        .pos     (plane_y)
    );

    fire_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] fire_x_q, fire_x_d;
    logic [COORD_W-1:0] fire_y_q, fire_y_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               drop_evt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fire_x_d = fire_x_q;
        fire_y_d = fire_y_q;
        drop_d   = drop_q;
        drop_evt = 1'b0;
        case (state_q)
            FIRE_IDLE: begin
                if (shoot) begin
                    state_d  = FIRE_REQ;
                    fire_x_d = plane_x + COORD_W'(FIRE_X_OFS);
                    fire_y_d = plane_y;
                end
            end
            FIRE_REQ: begin
                drop_evt = shoot;
                if (fire_ready) begin
                    if (COOLDOWN == 0) begin
                        state_d = FIRE_IDLE;
                    end else begin
                        state_d = FIRE_COOL;
                        cnt_d   = CNT_W'(COOLDOWN);
                    end
                end
            end
            FIRE_COOL: begin
                // Still COOL during the tick that ends the cooldown, so a
                // shoot in that cycle is dropped as well.
                drop_evt = shoot;
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = FIRE_IDLE;
                    end
                end
            end
            default: begin
                state_d = FIRE_IDLE;
            end
        endcase
        if (drop_evt && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FIRE_IDLE;
            cnt_q    <= '0;
            fire_x_q <= '0;
            fire_y_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fire_x_q <= fire_x_d;
            fire_y_q <= fire_y_d;
            drop_q   <= drop_d;
        end
    end

    assign fire_valid = (state_q == FIRE_REQ);
    assign fire_x     = fire_x_q;
    assign fire_y     = fire_y_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_plane_ctrl.sv
module tb_plane_ctrl;
    import plane_pkg::*;

    localparam int STEP = 8;
    localparam int XMAX = 608;
    localparam int YMAX = 448;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic shoot = 1'b0, frame_tick = 1'b0, fire_ready = 1'b0;

    logic [9:0] plane_x, plane_y, fire_x, fire_y;
    logic       fire_valid;
    logic [7:0] drop_cnt;

    logic [9:0] plane_x_b, plane_y_b, fire_x_b, fire_y_b;
    logic       fire_valid_b;
    logic [7:0] drop_cnt_b;

    always #5 clk = ~clk;

    plane_ctrl dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .shoot(shoot), .frame_tick(frame_tick), .plane_x(plane_x), .plane_y(plane_y),
        .fire_valid(fire_valid), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ready(fire_ready), .drop_cnt(drop_cnt)
    );

    // Second instance: starts near the right/top edges, no cooldown.
    plane_ctrl #(.X_START(604), .Y_START(4), .COOLDOWN(0)) dut_b (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .shoot(shoot), .frame_tick(frame_tick), .plane_x(plane_x_b), .plane_y(plane_y_b),
        .fire_valid(fire_valid_b), .fire_x(fire_x_b), .fire_y(fire_y_b),
        .fire_ready(fire_ready), .drop_cnt(drop_cnt_b)
    );

    int checks = 0;
    int errors = 0;
    int mx, my, mx_b, my_b;
    logic [19:0] pos_sb[$];
    logic [19:0] pos_sb_b[$];
    logic [19:0] fire_sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mv(input int p, input bit dec, input bit inc, input int lim);
        if (dec && !inc) return (p < STEP) ? 0 : p - STEP;
        if (inc && !dec) return (p + STEP > lim) ? lim : p + STEP;
        return p;
    endfunction

    task automatic step(input bit u, input bit d, input bit l, input bit r,
                        input bit s, input bit t);
        up = u; down = d; left = l; right = r; shoot = s; frame_tick = t;
        @(posedge clk); #1;
        up = 0; down = 0; left = 0; right = 0; shoot = 0; frame_tick = 0;
    endtask

    task automatic model_reset();
        mx = 304; my = 440; mx_b = 604; my_b = 4;
        pos_sb.delete(); pos_sb_b.delete(); fire_sb.delete();
    endtask

    // u/d/l/r are the flags the frame applies; co drives them in the tick cycle.
    task automatic frame(input bit u, input bit d, input bit l, input bit r,
                         input bit co, input bit s, input string tag);
        logic [19:0] e;
        mx   = mv(mx,   l, r, XMAX);
        my   = mv(my,   u, d, YMAX);
        mx_b = mv(mx_b, l, r, XMAX);
        my_b = mv(my_b, u, d, YMAX);
        pos_sb.push_back({mx[9:0], my[9:0]});
        pos_sb_b.push_back({mx_b[9:0], my_b[9:0]});
        if (co) step(u, d, l, r, s, 1'b1);
        else    step(1'b0, 1'b0, 1'b0, 1'b0, s, 1'b1);
        e = pos_sb.pop_front();
        chk({tag, " x"}, {22'd0, plane_x}, {22'd0, e[19:10]});
        chk({tag, " y"}, {22'd0, plane_y}, {22'd0, e[9:0]});
        e = pos_sb_b.pop_front();
        chk({tag, " b.x"}, {22'd0, plane_x_b}, {22'd0, e[19:10]});
        chk({tag, " b.y"}, {22'd0, plane_y_b}, {22'd0, e[9:0]});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " plane_x"}, {22'd0, plane_x}, 32'd304);
        chk({tag, " plane_y"}, {22'd0, plane_y}, 32'd440);
        chk({tag, " fire_valid"}, {31'd0, fire_valid}, 32'd0);
        chk({tag, " fire_x"}, {22'd0, fire_x}, 32'd0);
        chk({tag, " fire_y"}, {22'd0, fire_y}, 32'd0);
        chk({tag, " drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
        chk({tag, " b.plane_x"}, {22'd0, plane_x_b}, 32'd604);
        chk({tag, " b.plane_y"}, {22'd0, plane_y_b}, 32'd4);
    endtask

    task automatic wait_handshake(input string tag);
        logic [19:0] e;
        bit done;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (fire_valid && fire_ready) begin
                e = fire_sb.pop_front();
                chk({tag, " fire_x"}, {22'd0, fire_x}, {22'd0, e[19:10]});
                chk({tag, " fire_y"}, {22'd0, fire_y}, {22'd0, e[9:0]});
                done = 1;
            end
            step(0, 0, 0, 0, 0, 0);
        end
        if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        rst = 0;
        chk_reset_outputs("reset");

        // A pulse alone only sets a pending flag.
        step(0, 0, 0, 1, 0, 0);
        chk("pending no move x", {22'd0, plane_x}, 32'd304);
        frame(0, 0, 0, 1, 0, 0, "right");
        frame(0, 0, 1, 0, 1, 0, "coincident left");

        // Three ups and a down cancel; three ups alone move one step.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        frame(1, 1, 0, 0, 0, 0, "cancel y");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0, "triple up");

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0);
            frame(0, 1, 0, 0, 0, 0, "down sat");
        end
        for (int i = 0; i < 39; i++) begin
            step(0, 0, 1, 0, 0, 0);
            frame(0, 0, 1, 0, 0, 0, "left sat");
        end
        chk("left floor", {22'd0, plane_x}, 32'd0);

        model_reset();
        rst = 1;
        step(0, 0, 0, 0, 0, 0);
        rst = 0;
        chk_reset_outputs("reset2");

        // Shoot, hold ready low, then handshake.
        fire_sb.push_back({10'd320, 10'd440});
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("req valid", {31'd0, fire_valid}, 32'd1);
            chk("req hold x", {22'd0, fire_x}, 32'd320);
            chk("req hold y", {22'd0, fire_y}, 32'd440);
            step(0, 0, 0, 0, 0, 0);
        end
        fire_ready = 1;
        wait_handshake("hs");
        fire_ready = 0;
        chk("post hs valid", {31'd0, fire_valid}, 32'd0);
        chk("post hs state", {30'd0, dut.state_q}, {30'd0, FIRE_COOL});
        chk("b zero cooldown state", {30'd0, dut_b.state_q}, {30'd0, FIRE_IDLE});

        step(0, 0, 0, 0, 1, 0);
        chk("cool drop", {24'd0, drop_cnt}, 32'd1);
        chk("cool no valid", {31'd0, fire_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            frame(0, 0, 0, 0, 0, 0, "cool tick");
            chk("still cool", {30'd0, dut.state_q}, {30'd0, FIRE_COOL});
        end
        frame(0, 0, 0, 0, 0, 1, "last cool tick");
        chk("back idle", {30'd0, dut.state_q}, {30'd0, FIRE_IDLE});
        chk("exit shoot dropped", {24'd0, drop_cnt}, 32'd2);
        chk("exit no valid", {31'd0, fire_valid}, 32'd0);

        fire_sb.push_back({10'd320, 10'd440});
        step(0, 0, 0, 0, 1, 0);
        chk("req2 valid", {31'd0, fire_valid}, 32'd1);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 0);
        chk("drop sat", {24'd0, drop_cnt}, 32'd255);
        chk("req2 hold x", {22'd0, fire_x}, 32'd320);
        chk("req2 valid hold", {31'd0, fire_valid}, 32'd1);

        // Reset wins over every input in the same cycle.
        rst = 1;
        fire_ready = 1;
        step(0, 1, 0, 1, 1, 1);
        rst = 0;
        fire_ready = 0;
        model_reset();
        chk_reset_outputs("rst in req");
        chk("rst state", {30'd0, dut.state_q}, {30'd0, FIRE_IDLE});
        frame(0, 0, 0, 0, 0, 0, "no stale pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
